// File: rtl/fifo_pack_rd_ctrl_pkg.sv
// fifo_pack_pkg: shared state encoding and default parameters for the FIFO pair-packing read controller.
package fifo_pack_pkg;
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CAP, OUT} state_t;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_USEDW_W   = 8;
  localparam int DEF_BURST_LEN = 8;
  localparam int DEF_TIMEOUT   = 64;
endpackage

// File: rtl/fifo_pack_rd_ctrl_if.sv
// fifo_pack_rd_ctrl_if: FIFO read port plus packed upstream handshake; master is the controller side.
interface fifo_pack_rd_ctrl_if
  import fifo_pack_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int USEDW_W = DEF_USEDW_W
);
  logic                rdempty;
  logic [USEDW_W-1:0]  rdusedw;
  logic [DATA_W-1:0]   q;
  logic                rdreq;
  logic                up_ready;
  logic                data_valid;
  logic [2*DATA_W-1:0] up_data;
  logic                busy;
  modport master (input rdempty, rdusedw, q, up_ready, output rdreq, data_valid, up_data, busy);
  modport slave  (output rdempty, rdusedw, q, up_ready, input rdreq, data_valid, up_data, busy);
endinterface

// File: rtl/fifo_pack_rd_ctrl.sv
// fifo_pack_rd_ctrl: reads FIFO words in bursts and presents them as packed {second, first} pairs.
// Optional lone-word timeout flush is enabled by defining PACK_FLUSH_EN.
module fifo_pack_rd_ctrl
  import fifo_pack_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int USEDW_W   = DEF_USEDW_W,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input logic               rdclk,
  input logic               rst_n,
  fifo_pack_rd_ctrl_if.master bus
);
  localparam int PAIR_W = $clog2(BURST_LEN / 2 + 1);
  if (BURST_LEN < 2 || BURST_LEN % 2 != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("fifo_pack_rd_ctrl: BURST_LEN must be even and >= 2, TIMEOUT >= 1");
  end
  state_t              r_state, w_next;
  logic [PAIR_W-1:0]   r_pairs;
  logic [DATA_W-1:0]   r_lo;
  logic [2*DATA_W-1:0] r_data;
  logic                w_burst, w_flush_go, w_flush, w_rd;
  assign w_burst = bus.rdusedw >= USEDW_W'(BURST_LEN);
`ifdef PACK_FLUSH_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] r_idle;
  logic              r_flush;
  logic              w_short;
  assign w_short    = bus.rdusedw != '0 && !w_burst;
  assign w_flush_go = r_state == IDLE && w_short && r_idle == IDLE_W'(TIMEOUT - 1);
  assign w_flush    = r_flush;
  always_ff @(posedge rdclk or negedge rst_n)
    if (!rst_n) begin
      r_idle  <= '0;
      r_flush <= 1'b0;
    end else begin
      r_idle  <= (r_state == IDLE && w_short && !w_flush_go) ? r_idle + IDLE_W'(1) : '0;
      r_flush <= r_state == IDLE ? w_flush_go : r_flush;
    end
`else
  assign w_flush_go = 1'b0;
  assign w_flush    = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    unique case (r_state)
      IDLE:  w_next = (w_burst || w_flush_go) ? RD_LO : IDLE;
      RD_LO: begin
        w_rd   = !bus.rdempty;
        w_next = bus.rdempty ? RD_LO : (w_flush ? CAP : RD_HI);
      end
      RD_HI: begin
        w_rd   = !bus.rdempty;
        w_next = bus.rdempty ? RD_HI : CAP;
      end
      CAP:   w_next = OUT;
      OUT:   w_next = bus.up_ready ? (r_pairs != '0 ? RD_LO : IDLE) : OUT;
      default: w_next = IDLE;
    endcase
  end
  // q lags rdreq by one cycle: RD_HI sees the first word, CAP sees the second
  always_ff @(posedge rdclk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_pairs <= '0;
      r_lo    <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == RD_LO)
        r_pairs <= w_flush_go ? PAIR_W'(1) : PAIR_W'(BURST_LEN / 2);
      if (r_state == CAP) r_pairs <= r_pairs - PAIR_W'(1);
      if (r_state == RD_HI) r_lo <= bus.q;
      if (r_state == CAP) r_data <= w_flush ? {DATA_W'(0), bus.q} : {bus.q, r_lo};
    end
  assign bus.rdreq      = w_rd;
  assign bus.data_valid = r_state == OUT;
  assign bus.up_data    = r_data;
  assign bus.busy       = r_state != IDLE;
endmodule
